// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline encodings for the hazard controller and its forwarding units.
package riscv_pipe_pkg;

   localparam int REG_AW_DEF = 5;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } hz_state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/riscv_fwd_unit.sv
// Operand bypass select for one ALU source: EX/MEM beats MEM/WB, x0 is never bypassed.
module riscv_fwd_unit
   import riscv_pipe_pkg::*;
#(
   parameter int REG_AW    = REG_AW_DEF,
   parameter int WB_BYPASS = 1
) (
   input  logic [REG_AW-1:0] i_rs,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic              i_mem_regwrite,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic              i_wb_regwrite,
   output logic [1:0]        o_sel
);

   fwd_sel_e w_sel;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_sel = FWD_RF;
      if (i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_rs)) begin
         w_sel = FWD_MEM;
      end else if ((WB_BYPASS != 0) && i_wb_regwrite && (i_wb_rd != '0) && (i_wb_rd == i_rs)) begin
         w_sel = FWD_WB;
      end
   end

   assign o_sel = w_sel;

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Load-use stall / taken-branch flush controller with operand forwarding and saturating
// performance counters. Hold and flush respond in the same cycle as their cause.
module riscv_hazard_ctrl
   import riscv_pipe_pkg::*;
#(
   parameter int REG_AW       = REG_AW_DEF,
   parameter int CNT_W        = 32,
   parameter int LU_STALL_CYC = 1,
   parameter int WB_BYPASS    = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rs1,
   input  logic [REG_AW-1:0] ex_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   input  logic              br_taken,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              idex_bubble,
   output logic              flush_ifid,
   output logic              flush_idex,
   output logic              flush_exmem,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0] STALL_INIT = 2'(LU_STALL_CYC - 1);

   hz_state_e        r_state;
   hz_state_e        w_state_nxt;
   logic [1:0]       r_remain;
   logic [1:0]       w_remain_nxt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_lu;
   logic             w_hold;
   logic             w_flush;
   logic             w_unused;

   // ex_regwrite is part of the ID/EX control bundle but a load already implies it.
   assign w_unused = ex_regwrite;

   riscv_fwd_unit #(.REG_AW(REG_AW), .WB_BYPASS(WB_BYPASS)) u_fwd_a (
      .i_rs           (ex_rs1),
      .i_mem_rd       (mem_rd),
      .i_mem_regwrite (mem_regwrite),
      .i_wb_rd        (wb_rd),
      .i_wb_regwrite  (wb_regwrite),
      .o_sel          (fwd_a)
   );

   riscv_fwd_unit #(.REG_AW(REG_AW), .WB_BYPASS(WB_BYPASS)) u_fwd_b (
      .i_rs           (ex_rs2),
      .i_mem_rd       (mem_rd),
      .i_mem_regwrite (mem_regwrite),
      .i_wb_rd        (wb_rd),
      .i_wb_regwrite  (wb_regwrite),
      .o_sel          (fwd_b)
   );

   assign w_lu = ex_memread && (ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      w_hold       = 1'b0;
      w_flush      = 1'b0;
      w_state_nxt  = r_state;
      w_remain_nxt = r_remain;
      case (r_state)
         ST_RUN: begin
            if (br_taken) begin
               w_flush     = 1'b1;
               w_state_nxt = ST_FLUSH;
            end else if (w_lu) begin
               w_hold = 1'b1;
               if (LU_STALL_CYC > 1) begin
                  w_state_nxt  = ST_STALL;
                  w_remain_nxt = STALL_INIT;
               end
            end
         end
         ST_STALL: begin
            if (br_taken) begin
               w_flush     = 1'b1;
               w_state_nxt = ST_FLUSH;
            end else begin
               w_hold = 1'b1;
               if (r_remain <= 2'd1) w_state_nxt = ST_RUN;
               else                  w_remain_nxt = r_remain - 2'd1;
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
      // Hold/flush are suppressed for as long as reset is high, not just after the edge.
      if (reset) begin
         w_hold  = 1'b0;
         w_flush = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_RUN;
         r_remain    <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_remain <= w_remain_nxt;
         if (w_hold && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign pc_hold     = w_hold;
   assign ifid_hold   = w_hold;
   assign idex_bubble = w_hold;
   assign flush_ifid  = w_flush;
   assign flush_idex  = w_flush;
   assign flush_exmem = w_flush;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl: four parameterisations share one stimulus stream,
// expected values are queued when a step is driven and popped when outputs are sampled.
module tb_riscv_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
   logic       mem_regwrite, wb_regwrite, br_taken;

   // dut_a: defaults (LU_STALL_CYC=1)
   logic a_pc_hold, a_ifid_hold, a_idex_bubble, a_flush_ifid, a_flush_idex, a_flush_exmem;
   logic [1:0]  a_fwd_a, a_fwd_b;
   logic [31:0] a_stall_cnt, a_flush_cnt;
   // dut_s3: LU_STALL_CYC=3
   logic s3_pc_hold, s3_ifid_hold, s3_idex_bubble, s3_flush_ifid, s3_flush_idex, s3_flush_exmem;
   logic [1:0]  s3_fwd_a, s3_fwd_b;
   logic [31:0] s3_stall_cnt, s3_flush_cnt;
   // dut_c4: CNT_W=4
   logic c4_pc_hold, c4_ifid_hold, c4_idex_bubble, c4_flush_ifid, c4_flush_idex, c4_flush_exmem;
   logic [1:0] c4_fwd_a, c4_fwd_b;
   logic [3:0] c4_stall_cnt, c4_flush_cnt;
   // dut_nb: WB_BYPASS=0
   logic nb_pc_hold, nb_ifid_hold, nb_idex_bubble, nb_flush_ifid, nb_flush_idex, nb_flush_exmem;
   logic [1:0]  nb_fwd_a, nb_fwd_b;
   logic [31:0] nb_stall_cnt, nb_flush_cnt;

   riscv_hazard_ctrl dut_a (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .br_taken(br_taken),
      .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .idex_bubble(a_idex_bubble),
      .flush_ifid(a_flush_ifid), .flush_idex(a_flush_idex), .flush_exmem(a_flush_exmem),
      .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
   );

   riscv_hazard_ctrl #(.LU_STALL_CYC(3)) dut_s3 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .br_taken(br_taken),
      .pc_hold(s3_pc_hold), .ifid_hold(s3_ifid_hold), .idex_bubble(s3_idex_bubble),
      .flush_ifid(s3_flush_ifid), .flush_idex(s3_flush_idex), .flush_exmem(s3_flush_exmem),
      .fwd_a(s3_fwd_a), .fwd_b(s3_fwd_b), .stall_cnt(s3_stall_cnt), .flush_cnt(s3_flush_cnt)
   );

   riscv_hazard_ctrl #(.CNT_W(4)) dut_c4 (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .br_taken(br_taken),
      .pc_hold(c4_pc_hold), .ifid_hold(c4_ifid_hold), .idex_bubble(c4_idex_bubble),
      .flush_ifid(c4_flush_ifid), .flush_idex(c4_flush_idex), .flush_exmem(c4_flush_exmem),
      .fwd_a(c4_fwd_a), .fwd_b(c4_fwd_b), .stall_cnt(c4_stall_cnt), .flush_cnt(c4_flush_cnt)
   );

   riscv_hazard_ctrl #(.WB_BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
      .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .br_taken(br_taken),
      .pc_hold(nb_pc_hold), .ifid_hold(nb_ifid_hold), .idex_bubble(nb_idex_bubble),
      .flush_ifid(nb_flush_ifid), .flush_idex(nb_flush_idex), .flush_exmem(nb_flush_exmem),
      .fwd_a(nb_fwd_a), .fwd_b(nb_fwd_b), .stall_cnt(nb_stall_cnt), .flush_cnt(nb_flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %0h expected none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   // Outputs are sampled 3 time units after inputs change, well before the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0; br_taken = 1'b0;
   endtask

   // Load in EX writing x7, ID instruction reads x7 through rs2.
   task automatic drive_lu();
      idle();
      ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7;
      id_rs2 = 5'd7; id_use_rs2 = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      reset = 1'b1;

      // Reset: hazards and branches present but everything must stay quiet.
      tick();
      drive_lu();
      br_taken = 1'b1;
      push("rst_pc_hold", 0); push("rst_idex_bubble", 0); push("rst_flush_exmem", 0);
      push("rst_flush_ifid", 0); push("rst_stall_cnt", 0); push("rst_flush_cnt", 0);
      settle();
      check(a_pc_hold); check(a_idex_bubble); check(a_flush_exmem);
      check(a_flush_ifid); check(a_stall_cnt); check(a_flush_cnt);
      tick();
      idle();
      reset = 1'b0;

      // Forwarding priority and x0 suppression.
      ex_rs1 = 5'd5; ex_rs2 = 5'd6;
      mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
      push("fwd_a_mem", 2); push("fwd_b_none", 0);
      settle();
      check(a_fwd_a); check(a_fwd_b);
      tick();
      mem_regwrite = 1'b0;
      push("fwd_a_wb", 1); push("fwd_a_wb_nobypass", 0);
      settle();
      check(a_fwd_a); check(nb_fwd_a);
      tick();
      wb_rd = 5'd6;
      push("fwd_b_wb", 1); push("fwd_a_after_wb_move", 0);
      settle();
      check(a_fwd_b); check(a_fwd_a);
      tick();
      mem_rd = '0; wb_rd = '0; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
      push("fwd_a_rd0", 0);
      settle();
      check(a_fwd_a);
      tick();
      ex_rs1 = '0;
      push("fwd_a_x0_src", 0);
      settle();
      check(a_fwd_a);
      tick();
      ex_rs2 = 5'd6; mem_rd = 5'd6; wb_rd = 5'd6;
      push("fwd_b_mem_over_wb", 2); push("fwd_b_mem_nobypass", 2);
      settle();
      check(a_fwd_b); check(nb_fwd_b);
      tick();

      // Load-use, one-cycle and three-cycle stalls.
      do_reset();
      idle();
      ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
      push("lu_unused_src", 0);
      settle();
      check(a_pc_hold);
      tick();
      drive_lu();
      push("lu1_pc_hold", 1); push("lu1_ifid_hold", 1); push("lu1_idex_bubble", 1);
      push("lu1_no_flush", 0); push("lu1_stall_cnt_before", 0);
      settle();
      check(a_pc_hold); check(a_ifid_hold); check(a_idex_bubble);
      check(a_flush_ifid); check(a_stall_cnt);
      tick();
      idle();
      push("lu1_released", 0); push("lu1_stall_cnt_after", 1); push("lu3_cycle2", 1);
      settle();
      check(a_pc_hold); check(a_stall_cnt); check(s3_pc_hold);
      tick();
      push("lu3_cycle3", 1);
      settle();
      check(s3_ifid_hold);
      tick();
      push("lu3_released", 0); push("lu3_stall_cnt", 3);
      settle();
      check(s3_pc_hold); check(s3_stall_cnt);
      tick();

      // Branch during a three-cycle stall.
      do_reset();
      drive_lu();
      push("abort_hold", 1); push("abort_hold_noflush", 0);
      settle();
      check(s3_pc_hold); check(s3_flush_exmem);
      tick();
      idle();
      br_taken = 1'b1;
      push("abort_flush_ifid", 1); push("abort_flush_idex", 1); push("abort_flush_exmem", 1);
      push("abort_no_hold", 0); push("abort_no_bubble", 0);
      settle();
      check(s3_flush_ifid); check(s3_flush_idex); check(s3_flush_exmem);
      check(s3_pc_hold); check(s3_idex_bubble);
      tick();
      push("abort_flushstate_exmem", 0); push("abort_flushstate_hold", 0);
      settle();
      check(s3_flush_exmem); check(s3_pc_hold);
      tick();
      drive_lu();
      push("abort_back_to_run", 1); push("abort_flush_cnt", 1); push("abort_stall_cnt", 1);
      settle();
      check(s3_pc_hold); check(s3_flush_cnt); check(s3_stall_cnt);
      tick();

      // Back-to-back branches; branch beats a simultaneous load-use.
      do_reset();
      drive_lu();
      br_taken = 1'b1;
      push("br1_flush_exmem", 1); push("br1_flush_ifid", 1); push("br1_flush_wins", 0);
      settle();
      check(a_flush_exmem); check(a_flush_ifid); check(a_pc_hold);
      tick();
      idle();
      br_taken = 1'b1;
      push("br2_ignored_exmem", 0); push("br2_ignored_idex", 0);
      settle();
      check(a_flush_exmem); check(a_flush_idex);
      tick();
      idle();
      push("br_after_flush_cnt", 1); push("br_after_quiet", 0);
      settle();
      check(a_flush_cnt); check(a_flush_exmem);
      tick();

      // Counter saturation on a 4-bit counter.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive_lu();
         if (i == 14) begin
            push("sat_cnt_14", 14);
            settle();
            check(c4_stall_cnt);
         end
         if (i == 19) begin
            push("sat_still_holding", 1); push("sat_cnt_19", 15);
            settle();
            check(c4_pc_hold); check(c4_stall_cnt);
         end
         tick();
      end
      idle();
      push("sat_cnt_final", 15); push("sat_released", 0);
      settle();
      check(c4_stall_cnt); check(c4_pc_hold);
      tick();

      // Reset in the second STALL cycle.
      do_reset();
      drive_lu();
      push("rs_run_hold", 1);
      settle();
      check(s3_pc_hold);
      tick();
      idle();
      push("rs_stall1_hold", 1);
      settle();
      check(s3_pc_hold);
      tick();
      br_taken = 1'b1;
      reset = 1'b1;
      push("rs_gated_hold", 0); push("rs_gated_flush", 0);
      settle();
      check(s3_pc_hold); check(s3_flush_exmem);
      tick();
      idle();
      reset = 1'b0;
      push("rs_after_hold", 0); push("rs_after_bubble", 0); push("rs_after_flush", 0);
      push("rs_after_stall_cnt", 0); push("rs_after_flush_cnt", 0);
      settle();
      check(s3_pc_hold); check(s3_idex_bubble); check(s3_flush_ifid);
      check(s3_stall_cnt); check(s3_flush_cnt);
      tick();
      drive_lu();
      push("rs_new_stall_c1", 1);
      settle();
      check(s3_pc_hold);
      tick();
      idle();
      push("rs_new_stall_c2", 1);
      settle();
      check(s3_pc_hold);
      tick();
      push("rs_new_stall_c3", 1);
      settle();
      check(s3_pc_hold);
      tick();
      push("rs_new_stall_done", 0);
      settle();
      check(s3_pc_hold);
      tick();

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
